// File: rtl/regfile_sb.sv
// General-purpose register file: NREAD combinational read ports with write bypass, one write
// port, a per-register busy scoreboard, and a sequential clear of storage after reset.

module regfile_sb_rport #(
  parameter int XLEN = 32
) (
  input  logic            in_range,
  input  logic            run,
  input  logic            hit,
  input  logic [XLEN-1:0] wr_data,
  input  logic [XLEN-1:0] reg_data,
  input  logic            reg_busy,
  output logic [XLEN-1:0] data,
  output logic            busy
);
  // Priority: hardwired/out-of-range, then init stall, then bypass, then storage.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (!in_range) begin
      data = '0;
    end else if (!run) begin
      busy = 1'b1;
    end else if (hit) begin
      data = wr_data;
    end else begin
      data = reg_data;
      busy = reg_busy;
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  flush,
  output logic                  ready
);
  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW:0]   NREGS_X = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS-1);
  localparam bit            ZR      = (ZERO_REG != 0);
  localparam bit            BP      = (BYPASS != 0);

  state_t           state, state_n;
  logic [AW-1:0]    idx, idx_n;
  logic [NREGS-1:0] busy, busy_n;
  logic [XLEN-1:0]  regs [NREGS];
  logic             run, wr_ok, iss_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_X) && !(ZR && (a == '0));
  endfunction

  assign run    = (state == RUN);
  assign ready  = run;
  assign wr_ok  = run && wr_en && addr_ok(wr_addr);
  assign iss_ok = run && iss_en && addr_ok(iss_addr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= INIT;
      idx   <= '0;
      busy  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      busy  <= busy_n;
    end
  end

  // Later scoreboard steps override earlier ones: flush, then writeback clear, then issue set.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    busy_n  = busy;
    case (state)
      INIT: begin
        idx_n = idx + AW'(1);
        if (idx == LAST) state_n = RUN;
      end
      RUN: begin
        if (flush)  busy_n           = '0;
        if (wr_ok)  busy_n[wr_addr]  = 1'b0;
        if (iss_ok) busy_n[iss_addr] = 1'b1;
      end
      default: state_n = INIT;
    endcase
  end

  // Storage has no reset; INIT walks through it instead.
  always_ff @(posedge clk) begin
    if (!run)      regs[idx]     <= '0;
    else if (wr_ok) regs[wr_addr] <= wr_data;
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic            ok;
    logic [XLEN-1:0] rv;
    logic            rb;

    assign a  = rd_addr[p*AW +: AW];
    assign ok = addr_ok(a);

    always_comb begin
      rv = '0;
      rb = 1'b0;
      if (ok) begin
        rv = regs[a];
        rb = busy[a];
      end
    end

    regfile_sb_rport #(.XLEN(XLEN)) u_rport (
      .in_range (ok),
      .run      (run),
      .hit      (BP && wr_en && (wr_addr == a)),
      .wr_data  (wr_data),
      .reg_data (rv),
      .reg_busy (rb),
      .data     (rd_data[p*XLEN +: XLEN]),
      .busy     (rd_busy[p])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two configurations share one stimulus stream and are compared against
// a per-configuration reference model, directed table rows and a randomized phase.

module tb_regfile_sb;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        wr_en, iss_en, flush;
  logic [4:0]  wr_addr, iss_addr;
  logic [31:0] wr_data;
  logic [4:0]  ra [3];

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_ready;
  logic [14:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_ready;

  assign a_rd_addr = {ra[1], ra[0]};
  assign b_rd_addr = {ra[2], ra[1], ra[0]};

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .resetn(resetn), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .ready(a_ready));

  regfile_sb #(.XLEN(32), .NREGS(24), .NREAD(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .resetn(resetn), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr),
    .flush(flush), .ready(b_ready));

  int checks = 0;
  int errors = 0;

  // Reference model: config 0 = dut_a, config 1 = dut_b.
  int          nregs_c [2] = '{32, 24};
  bit          byp_c   [2] = '{1'b1, 1'b0};
  int          nrd_c   [2] = '{2, 3};
  logic [31:0] m_regs  [2][32];
  bit          m_busy  [2][32];
  bit          m_run   [2];
  int          m_cnt   [2];

  function automatic bit m_valid(int c, int a);
    return (a != 0) && (a < nregs_c[c]);
  endfunction

  function automatic void m_reset();
    for (int c = 0; c < 2; c++) begin
      m_run[c] = 1'b0;
      m_cnt[c] = 0;
      for (int r = 0; r < 32; r++) begin
        m_regs[c][r] = '0;
        m_busy[c][r] = 1'b0;
      end
    end
  endfunction

  function automatic void m_edge();
    for (int c = 0; c < 2; c++) begin
      if (!resetn) begin
        m_run[c] = 1'b0;
        m_cnt[c] = 0;
        for (int r = 0; r < 32; r++) m_busy[c][r] = 1'b0;
      end else if (!m_run[c]) begin
        m_cnt[c]++;
        if (m_cnt[c] == nregs_c[c]) begin
          m_run[c] = 1'b1;
          for (int r = 0; r < 32; r++) m_regs[c][r] = '0;
        end
      end else begin
        if (flush) for (int r = 0; r < 32; r++) m_busy[c][r] = 1'b0;
        if (wr_en && m_valid(c, int'(wr_addr))) begin
          m_regs[c][wr_addr] = wr_data;
          m_busy[c][wr_addr] = 1'b0;
        end
        if (iss_en && m_valid(c, int'(iss_addr))) m_busy[c][iss_addr] = 1'b1;
      end
    end
  endfunction

  function automatic void m_read(int c, int a, output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (!m_valid(c, a)) begin
      d = '0;
    end else if (!m_run[c]) begin
      b = 1'b1;
    end else if (byp_c[c] && wr_en && (int'(wr_addr) == a)) begin
      d = wr_data;
    end else begin
      d = m_regs[c][a];
      b = m_busy[c][a];
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_data(int c, int p);
    return (c == 0) ? a_rd_data[p*32 +: 32] : b_rd_data[p*32 +: 32];
  endfunction

  function automatic logic dut_busy(int c, int p);
    return (c == 0) ? a_rd_busy[p] : b_rd_busy[p];
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] d;
    logic        b;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s cfg%0d ready", tag, c), {31'b0, (c == 0) ? a_ready : b_ready},
            {31'b0, m_run[c]});
      for (int p = 0; p < nrd_c[c]; p++) begin
        m_read(c, int'(ra[p]), d, b);
        check($sformatf("%s cfg%0d p%0d x%0d data", tag, c, p, ra[p]), dut_data(c, p), d);
        check($sformatf("%s cfg%0d p%0d x%0d busy", tag, c, p, ra[p]), {31'b0, dut_busy(c, p)},
              {31'b0, b});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  // Walks through INIT; ready must rise after exactly 24 (cfg1) and 32 (cfg0) edges.
  task automatic run_init(input string tag);
    idle();
    ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
    for (int e = 0; e <= 32; e++) begin
      #1;
      check($sformatf("%s ready_a e%0d", tag, e), {31'b0, a_ready}, {31'b0, (e >= 32)});
      check($sformatf("%s ready_b e%0d", tag, e), {31'b0, b_ready}, {31'b0, (e >= 24)});
      check_all(tag);
      tick();
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [31:0] ad;
    logic        ab;
    logic [31:0] bd;
    logic        bb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    resetn = 1'b0;
    idle();
    ra[0] = '0; ra[1] = '0; ra[2] = '0;
    m_reset();
    #2;
    check("reset ready_a", {31'b0, a_ready}, 32'd0);
    check("reset ready_b", {31'b0, b_ready}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_init("init");

    // x1..x31 all read zero and idle after init.
    for (int r = 1; r < 32; r++) begin
      ra[0] = 5'(r); ra[1] = 5'(31 - r); ra[2] = 5'(r);
      #1;
      check($sformatf("post_init x%0d", r), a_rd_data[31:0], 32'd0);
      check($sformatf("post_init x%0d busy", r), {31'b0, a_rd_busy[0]}, 32'd0);
      check_all("post_init");
    end

    //            rd    we    wa     wd            ie    ia     fl    ad            ab    bd            bb
    tbl.push_back('{5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0});
    tbl.push_back('{5'd0,  1'b1, 5'd0,  32'h00001234, 1'b1, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd7,  1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{5'd7,  1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0,  1'b0, 32'h55,       1'b0, 32'h0,        1'b1});
    tbl.push_back('{5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h55,       1'b0, 32'h55,       1'b0});
    tbl.push_back('{5'd7,  1'b1, 5'd7,  32'h00000066, 1'b1, 5'd7,  1'b0, 32'h66,       1'b0, 32'h55,       1'b0});
    tbl.push_back('{5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h66,       1'b1, 32'h66,       1'b1});
    tbl.push_back('{5'd3,  1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd3,  1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{5'd4,  1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{5'd9,  1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 1'b1, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd12, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b1});
    tbl.push_back('{5'd7,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h66,       1'b0, 32'h66,       1'b0});
    tbl.push_back('{5'd3,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd24, 1'b1, 5'd24, 32'h0000ABCD, 1'b0, 5'd0,  1'b0, 32'hABCD,     1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd24, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'hABCD,     1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd26, 1'b0, 5'd0,  32'h0,        1'b1, 5'd26, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0});
    tbl.push_back('{5'd26, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 32'h0,        1'b1, 32'h0,        1'b0});

    foreach (tbl[i]) begin
      ra[0] = tbl[i].rd; ra[1] = 5'd12; ra[2] = 5'd31;
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      iss_en = tbl[i].ie; iss_addr = tbl[i].ia; flush = tbl[i].fl;
      #1;
      check($sformatf("vec%0d a data", i), a_rd_data[31:0], tbl[i].ad);
      check($sformatf("vec%0d a busy", i), {31'b0, a_rd_busy[0]}, {31'b0, tbl[i].ab});
      check($sformatf("vec%0d b data", i), b_rd_data[31:0], tbl[i].bd);
      check($sformatf("vec%0d b busy", i), {31'b0, b_rd_busy[0]}, {31'b0, tbl[i].bb});
      check_all($sformatf("vec%0d", i));
      tick();
    end

    // Asynchronous reset in mid-cycle after x5 holds a value.
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5A5A5;
    tick();
    idle();
    ra[0] = 5'd5;
    #1;
    check("x5 before reset a", a_rd_data[31:0], 32'hA5A5A5A5);
    check("x5 before reset b", b_rd_data[31:0], 32'hA5A5A5A5);
    #1;
    resetn = 1'b0;
    #1;
    check("async ready_a", {31'b0, a_ready}, 32'd0);
    check("async ready_b", {31'b0, b_ready}, 32'd0);
    m_reset();
    resetn = 1'b1;
    run_init("reinit");
    ra[0] = 5'd5; ra[1] = 5'd5; ra[2] = 5'd5;
    #1;
    check("x5 after reinit a", a_rd_data[31:0], 32'd0);
    check("x5 after reinit b", b_rd_data[31:0], 32'd0);
    check_all("reinit");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 3; p++) ra[p] = 5'($urandom_range(0, 31));
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      flush    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) ra[0] = wr_addr;
      #1;
      check_all($sformatf("rnd%0d", n));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
